// File: rtl/stdp_pkg.sv
// -----------------------------------------------------------------------------
// stdp_pkg
// Shared types and constants for the STDP synapse controller:
//   - stdp_state_t : pairing FSM state (2 bits)
//   - TIMER_MAX    : last timer value still inside the pairing window
//   - BIN_EDGE_*   : upper inclusive time_diff edge of each delta bin
//   - DELTA_BIN*   : weight step applied for each bin (LTP and LTD alike)
// -----------------------------------------------------------------------------
package stdp_pkg;

    localparam int unsigned W_W  = 8;   // weight / current width
    localparam int unsigned TD_W = 4;   // timer / time_diff width

    localparam logic [TD_W-1:0] TIMER_MAX  = 4'd15;

    localparam logic [TD_W-1:0] BIN_EDGE_0 = 4'd3;
    localparam logic [TD_W-1:0] BIN_EDGE_1 = 4'd7;
    localparam logic [TD_W-1:0] BIN_EDGE_2 = 4'd11;

    localparam logic [W_W-1:0]  DELTA_BIN0 = 8'd16;
    localparam logic [W_W-1:0]  DELTA_BIN1 = 8'd8;
    localparam logic [W_W-1:0]  DELTA_BIN2 = 8'd4;
    localparam logic [W_W-1:0]  DELTA_BIN3 = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_SEEN  = 2'd1,
        ST_POST_SEEN = 2'd2,
        ST_UPDATE    = 2'd3
    } stdp_state_t;

endpackage : stdp_pkg

// File: rtl/stdp_delta_lut.sv
// -----------------------------------------------------------------------------
// stdp_delta_lut
// Combinational map from pairing interval to weight step. Closer spike pairs
// give larger steps; the same table serves potentiation and depression.
//   time_diff_i [3:0] : spike interval in cycles (1..15 in normal use)
//   delta_o     [7:0] : weight step magnitude
// -----------------------------------------------------------------------------
module stdp_delta_lut
    import stdp_pkg::*;
(
    input  logic [TD_W-1:0] time_diff_i,
    output logic [W_W-1:0]  delta_o
);

    // Interval 0 never occurs after a real pairing; it falls into the nearest bin.
    always_comb begin
        delta_o = DELTA_BIN3;
        if (time_diff_i <= BIN_EDGE_0) begin
            delta_o = DELTA_BIN0;
        end else if (time_diff_i <= BIN_EDGE_1) begin
            delta_o = DELTA_BIN1;
        end else if (time_diff_i <= BIN_EDGE_2) begin
            delta_o = DELTA_BIN2;
        end
    end

endmodule : stdp_delta_lut

// File: rtl/stdp_controller.sv
// -----------------------------------------------------------------------------
// stdp_controller
// Single-synapse learning controller placed between a presynaptic and a
// postsynaptic lif neuron. Pairs pre/post spikes with a saturating window
// timer, applies a binned pair-based STDP step to an 8-bit weight, and gates
// the weight onto the synaptic current on each presynaptic spike.
//   clk, rst        : clock, synchronous active-high reset
//   pre_spike       : presynaptic spike pulse
//   post_spike      : postsynaptic spike pulse
//   learn_en        : enables pairing and weight updates
//   w_load/_val     : direct weight load (wins over an update)
//   weight          : current synaptic weight
//   syn_current     : registered weight gated by pre_spike
//   update_w_flag   : high during the single UPDATE cycle
//   ltp             : direction of the latest update (1 = potentiation)
//   time_diff       : interval of the latest pairing, held afterwards
//   busy            : controller not idle
// -----------------------------------------------------------------------------
module stdp_controller
    import stdp_pkg::*;
#(
    parameter logic [7:0] W_INIT = 8'd64,
    parameter logic [7:0] W_MAX  = 8'd255,
    parameter logic [7:0] W_MIN  = 8'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pre_spike,
    input  logic            post_spike,
    input  logic            learn_en,
    input  logic            w_load,
    input  logic [W_W-1:0]  w_load_val,
    output logic [W_W-1:0]  weight,
    output logic [W_W-1:0]  syn_current,
    output logic            update_w_flag,
    output logic            ltp,
    output logic [TD_W-1:0] time_diff,
    output logic            busy
);

    stdp_state_t     state_q, state_d;
    logic [TD_W-1:0] timer_q, timer_d;
    logic [W_W-1:0]  weight_q, weight_d;
    logic [W_W-1:0]  syn_q, syn_d;
    logic            flag_q, flag_d;
    logic            ltp_q, ltp_d;
    logic [TD_W-1:0] td_q, td_d;
    logic            busy_q, busy_d;

    logic [W_W-1:0]  delta;
    logic [W_W:0]    sum9;
    logic [W_W:0]    diff9;
    logic            pairing;

    stdp_delta_lut u_delta_lut (
        .time_diff_i (td_q),
        .delta_o     (delta)
    );

    // 9-bit arithmetic so overflow / borrow is visible before clamping.
    assign sum9  = {1'b0, weight_q} + {1'b0, delta};
    assign diff9 = {1'b0, weight_q} - {1'b0, delta};

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            weight_q <= W_INIT;
            syn_q    <= '0;
            flag_q   <= 1'b0;
            ltp_q    <= 1'b0;
            td_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            weight_q <= weight_d;
            syn_q    <= syn_d;
            flag_q   <= flag_d;
            ltp_q    <= ltp_d;
            td_q     <= td_d;
            busy_q   <= busy_d;
        end
    end

    // Pairing FSM and window timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!learn_en) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                // UPDATE re-arms from the spikes seen during it, like IDLE.
                ST_IDLE, ST_UPDATE: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    if (pre_spike && !post_spike) begin
                        state_d = ST_PRE_SEEN;
                        timer_d = TD_W'(1);
                    end else if (post_spike && !pre_spike) begin
                        state_d = ST_POST_SEEN;
                        timer_d = TD_W'(1);
                    end
                end
                ST_PRE_SEEN: begin
                    if (post_spike) begin
                        state_d = ST_UPDATE;
                        timer_d = '0;
                    end else if (pre_spike) begin
                        // Nearest-neighbour: a newer pre replaces the old one.
                        timer_d = TD_W'(1);
                    end else if (timer_q == TIMER_MAX) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TD_W'(1);
                    end
                end
                ST_POST_SEEN: begin
                    if (pre_spike) begin
                        state_d = ST_UPDATE;
                        timer_d = '0;
                    end else if (post_spike) begin
                        timer_d = TD_W'(1);
                    end else if (timer_q == TIMER_MAX) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign pairing = (state_d == ST_UPDATE) &&
                     ((state_q == ST_PRE_SEEN) || (state_q == ST_POST_SEEN));

    // Next values of the registered outputs.
    always_comb begin
        weight_d = weight_q;
        ltp_d    = ltp_q;
        td_d     = td_q;
        syn_d    = pre_spike ? weight_q : '0;
        flag_d   = (state_d == ST_UPDATE);
        busy_d   = (state_d != ST_IDLE);

        if (pairing) begin
            ltp_d = (state_q == ST_PRE_SEEN);
            td_d  = timer_q;
        end

        // A load discards any delta computed in the same cycle.
        if (w_load) begin
            weight_d = w_load_val;
        end else if ((state_q == ST_UPDATE) && learn_en) begin
            if (ltp_q) begin
                weight_d = (sum9 > {1'b0, W_MAX}) ? W_MAX : sum9[W_W-1:0];
            end else begin
                weight_d = (diff9[W_W] || (diff9[W_W-1:0] < W_MIN)) ? W_MIN
                                                                    : diff9[W_W-1:0];
            end
        end
    end

    assign weight        = weight_q;
    assign syn_current   = syn_q;
    assign update_w_flag = flag_q;
    assign ltp           = ltp_q;
    assign time_diff     = td_q;
    assign busy          = busy_q;

endmodule : stdp_controller

// File: tb/tb_stdp_controller.sv
// -----------------------------------------------------------------------------
// tb_stdp_controller
// Directed scenarios with fixed expected values, followed by a randomized run
// checked against a timestamp-based reference model of the synapse.
// -----------------------------------------------------------------------------
module tb_stdp_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pre_spike = 1'b0;
    logic       post_spike = 1'b0;
    logic       learn_en = 1'b1;
    logic       w_load = 1'b0;
    logic [7:0] w_load_val = 8'd0;
    logic [7:0] weight;
    logic [7:0] syn_current;
    logic       update_w_flag;
    logic       ltp;
    logic [3:0] time_diff;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // {weight, syn_current, update_w_flag, ltp, time_diff, busy}
    logic [22:0] obs;
    assign obs = {weight, syn_current, update_w_flag, ltp, time_diff, busy};

    localparam logic [22:0] RESET_VEC = {8'd64, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0};

    always #5 clk = ~clk;

    stdp_controller dut (
        .clk           (clk),
        .rst           (rst),
        .pre_spike     (pre_spike),
        .post_spike    (post_spike),
        .learn_en      (learn_en),
        .w_load        (w_load),
        .w_load_val    (w_load_val),
        .weight        (weight),
        .syn_current   (syn_current),
        .update_w_flag (update_w_flag),
        .ltp           (ltp),
        .time_diff     (time_diff),
        .busy          (busy)
    );

    // Reference model: an unpaired spike is remembered as (kind, timestamp);
    // a pairing produces dt = now - timestamp; the anchor is forgotten once
    // 15 cycles pass without a spike.
    int m_t      = 0;
    int m_anchor = 0;     // 0 none, 1 pre, 2 post
    int m_at     = 0;
    int m_upd    = 0;
    int m_ltp    = 0;
    int m_td     = 0;
    int m_w      = 64;
    int m_syn    = 0;

    function automatic int delta_of(input int dt);
        if (dt <= 3)  return 16;
        if (dt <= 7)  return 8;
        if (dt <= 11) return 4;
        return 2;
    endfunction

    task automatic model_step();
        int nw;
        m_t++;
        if (rst) begin
            m_anchor = 0; m_upd = 0; m_ltp = 0; m_td = 0; m_w = 64; m_syn = 0;
        end else begin
            m_syn = pre_spike ? m_w : 0;
            nw = m_w;
            if (w_load) begin
                nw = int'(w_load_val);
            end else if (m_upd != 0 && learn_en) begin
                if (m_ltp != 0) nw = (m_w + delta_of(m_td) > 255) ? 255 : m_w + delta_of(m_td);
                else            nw = (m_w - delta_of(m_td) < 0)   ? 0   : m_w - delta_of(m_td);
            end
            m_w = nw;
            if (!learn_en) begin
                m_anchor = 0; m_upd = 0;
            end else if (m_upd != 0 || m_anchor == 0) begin
                m_upd = 0;
                if (pre_spike && !post_spike)      begin m_anchor = 1; m_at = m_t; end
                else if (post_spike && !pre_spike) begin m_anchor = 2; m_at = m_t; end
                else m_anchor = 0;
            end else begin
                logic partner;
                logic same;
                partner = (m_anchor == 1) ? post_spike : pre_spike;
                same    = (m_anchor == 1) ? pre_spike  : post_spike;
                if (partner) begin
                    m_upd = 1; m_ltp = (m_anchor == 1) ? 1 : 0; m_td = m_t - m_at; m_anchor = 0;
                end else if (same) begin
                    m_at = m_t;
                end else if (m_t - m_at >= 15) begin
                    m_anchor = 0;
                end
            end
        end
    endtask

    function automatic logic [22:0] model_vec();
        return {8'(m_w), 8'(m_syn), m_upd != 0, m_ltp != 0, 4'(m_td),
                (m_upd != 0) || (m_anchor != 0)};
    endfunction

    // One clock: apply spikes, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        learn_en = 1'b0;
        cyc(1'b0, 1'b0);
        learn_en = 1'b1;
    endtask

    task automatic load(input logic [7:0] v);
        w_load = 1'b1; w_load_val = v;
        cyc(1'b0, 1'b0);
        w_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset: got %h expected %h", obs, RESET_VEC);
        end
    endtask

    task automatic test_syn_current();
        cyc(1'b1, 1'b0);
        n_tests++;
        if (obs !== {8'd64, 8'd64, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL syn_current: got %h expected %h", obs,
                               {8'd64, 8'd64, 1'b0, 1'b0, 4'd0, 1'b1});
        end
        cyc(1'b0, 1'b0);
        n_tests++;
        if (syn_current !== 8'd0) begin
            n_fail++; $display("FAIL syn_current_clear: got %0d expected 0", syn_current);
        end
        flush();
    endtask

    task automatic test_ltp();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        n_tests++;
        if (obs !== {8'd64, 8'd0, 1'b1, 1'b1, 4'd2, 1'b1}) begin
            n_fail++; $display("FAIL ltp_flag: got %h expected %h", obs,
                               {8'd64, 8'd0, 1'b1, 1'b1, 4'd2, 1'b1});
        end
        cyc(1'b0, 1'b0);
        n_tests++;
        if (obs !== {8'd80, 8'd0, 1'b0, 1'b1, 4'd2, 1'b0}) begin
            n_fail++; $display("FAIL ltp_weight: got %h expected %h", obs,
                               {8'd80, 8'd0, 1'b0, 1'b1, 4'd2, 1'b0});
        end
    endtask

    task automatic test_ltd();
        load(8'd64);
        cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        n_tests++;
        if (obs !== {8'd64, 8'd64, 1'b1, 1'b0, 4'd9, 1'b1}) begin
            n_fail++; $display("FAIL ltd_flag: got %h expected %h", obs,
                               {8'd64, 8'd64, 1'b1, 1'b0, 4'd9, 1'b1});
        end
        cyc(1'b0, 1'b0);
        n_tests++;
        if (weight !== 8'd60) begin
            n_fail++; $display("FAIL ltd_weight: got %0d expected 60", weight);
        end
    endtask

    task automatic test_saturation();
        load(8'd250);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        n_tests++;
        if (obs !== {8'd255, 8'd0, 1'b0, 1'b1, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL sat_high: got %h expected %h", obs,
                               {8'd255, 8'd0, 1'b0, 1'b1, 4'd1, 1'b0});
        end
        load(8'd5);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        n_tests++;
        if (obs !== {8'd0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0}) begin
            n_fail++; $display("FAIL sat_low: got %h expected %h", obs,
                               {8'd0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0});
        end
    endtask

    task automatic test_window();
        load(8'd64);
        cyc(1'b1, 1'b0);
        repeat (14) cyc(1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL window_open: busy got %b expected 1", busy);
        end
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({busy, update_w_flag} !== 2'b00) begin
            n_fail++; $display("FAIL window_expire: busy/flag got %b expected 00",
                               {busy, update_w_flag});
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({weight, update_w_flag, busy} !== {8'd64, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL window_late_post: got %h expected %h",
                               {weight, update_w_flag, busy}, {8'd64, 1'b0, 1'b1});
        end
        flush();
    endtask

    task automatic test_simultaneous();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({weight, update_w_flag, busy} !== {8'd64, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL simultaneous: got %h expected %h",
                               {weight, update_w_flag, busy}, {8'd64, 1'b0, 1'b0});
        end
    endtask

    task automatic test_learn_disable();
        cyc(1'b1, 1'b0);
        learn_en = 1'b0;
        cyc(1'b0, 1'b1);
        learn_en = 1'b1;
        n_tests++;
        if ({weight, update_w_flag, busy} !== {8'd64, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL learn_disable: got %h expected %h",
                               {weight, update_w_flag, busy}, {8'd64, 1'b0, 1'b0});
        end
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({weight, update_w_flag} !== {8'd64, 1'b0}) begin
            n_fail++; $display("FAIL learn_disable_after: got %h expected %h",
                               {weight, update_w_flag}, {8'd64, 1'b0});
        end
    endtask

    task automatic test_wload_update();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        n_tests++;
        if (update_w_flag !== 1'b1) begin
            n_fail++; $display("FAIL wload_flag: got %b expected 1", update_w_flag);
        end
        w_load = 1'b1; w_load_val = 8'd100;
        cyc(1'b0, 1'b0);
        w_load = 1'b0;
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({weight, update_w_flag} !== {8'd100, 1'b0}) begin
            n_fail++; $display("FAIL wload_weight: got %h expected %h",
                               {weight, update_w_flag}, {8'd100, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        n_tests++;
        if ({weight, update_w_flag, busy} !== {8'd116, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h",
                               {weight, update_w_flag, busy}, {8'd116, 1'b0, 1'b1});
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        n_tests++;
        if ({weight, ltp, time_diff} !== {8'd132, 1'b1, 4'd1}) begin
            n_fail++; $display("FAIL b2b_second: got %h expected %h",
                               {weight, ltp, time_diff}, {8'd132, 1'b1, 4'd1});
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_pre_seen: got %h expected %h", obs, RESET_VEC);
        end
        load(8'd200);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_update: got %h expected %h", obs, RESET_VEC);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 999) < 4);
            learn_en   = ($urandom_range(0, 99) >= 3);
            w_load     = ($urandom_range(0, 99) < 2);
            w_load_val = 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 99) < 18), ($urandom_range(0, 99) < 18));
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 20)
                    $display("FAIL random[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        rst = 1'b0; learn_en = 1'b1; w_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_syn_current();
        test_ltp();
        test_ltd();
        test_saturation();
        test_window();
        test_simultaneous();
        test_learn_disable();
        test_wload_update();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stdp_controller

// File: doc/stdp_controller.md
# stdp_controller

Sequencing controller for one synapse between the presynaptic and postsynaptic `lif` neurons. It watches the two spike trains, measures pre/post spike timing with a saturating window timer, and runs a small state machine that applies a binned pair-based STDP update to an 8-bit weight register. It also presents the gated synaptic current (weight × presynaptic spike) that drives the postsynaptic neuron. It sits between the two `lif` instances in the top level.

## Interface

Parameters:
- `W_INIT`, 8'd64: weight value after reset.
- `W_MAX`, 8'd255: upper saturation bound.
- `W_MIN`, 8'd0: lower saturation bound.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pre_spike`  in  1  presynaptic spike, one-cycle pulse per spike.
- `post_spike`  in  1  postsynaptic spike, one-cycle pulse per spike.
- `learn_en`  in  1  enables timing and weight updates.
- `w_load`  in  1  loads `w_load_val` into the weight.
- `w_load_val`  in  8  weight value to load.
- `weight`  out  8  current synaptic weight.
- `syn_current`  out  8  registered: `weight` if `pre_spike`, else 0.
- `update_w_flag`  out  1  high for the single UPDATE cycle.
- `ltp`  out  1  during UPDATE: 1 = potentiation, 0 = depression.
- `time_diff`  out  4  spike interval of the pairing in progress; held after UPDATE.
- `busy`  out  1  state is not IDLE.

## Operation

- States: IDLE, PRE_SEEN, POST_SEEN, UPDATE.
- IDLE:
  - pre only -> PRE_SEEN with timer = 1.
  - post only -> POST_SEEN with timer = 1.
  - pre and post together -> stay IDLE, no update.
- PRE_SEEN, each cycle:
  - post, with or without pre -> UPDATE. Latch `time_diff` = timer and set `ltp` = 1.
  - pre only -> timer restarts at 1 (nearest-neighbour pairing).
  - no spike with timer < 15 -> timer + 1.
  - no spike with timer = 15 -> IDLE (window expired).
- POST_SEEN: mirror of PRE_SEEN.
  - pre, with or without post -> UPDATE with `ltp` = 0.
  - post only -> timer restarts at 1.
- Delta bins by `time_diff` (same bins for LTP and LTD):
  - 1–3 -> 16
  - 4–7 -> 8
  - 8–11 -> 4
  - 12–15 -> 2
- UPDATE (one cycle): `update_w_flag` = 1. At the closing edge:
  - LTP: weight <= min(weight + delta, W_MAX).
  - LTD: weight <= max(weight − delta, W_MIN).
  - Compute in 9 bits, then clamp.
- After UPDATE, next state is chosen from the spikes sampled during the UPDATE cycle, using the IDLE rules.
- `learn_en` = 0: state is forced to IDLE at the next edge, the timer clears, `weight` is held, and no flag is raised. `syn_current` keeps operating.
- `w_load` has priority over any update in the same cycle:
  - weight <= `w_load_val`.
  - A concurrent UPDATE still sets the flag for one cycle, but the delta is discarded.
- `syn_current` <= `pre_spike` ? `weight` : 0, using the pre-edge `weight`.

## Timing

- Reset values: state IDLE, timer 0, `weight` = W_INIT, `syn_current` 0, `update_w_flag` 0, `ltp` 0, `time_diff` 0, `busy` 0.
- Reset mid-pairing or mid-UPDATE aborts it; `weight` reverts to W_INIT.
- `pre_spike` sampled at edge N -> PRE_SEEN from cycle N+1, timer = 1.
- Pairing spike sampled at edge M -> UPDATE during cycle M+1 (flag high) -> new `weight` visible from cycle M+2.
- Peak update rate: one update every 2 cycles (UPDATE, then PRE_SEEN/POST_SEEN via a spike during UPDATE, then UPDATE).
- `syn_current` latency: 1 cycle after `pre_spike`.
- Spike inputs are sampled only; no synchroniser. Inputs are already in the `clk` domain.

## Structure

- Package `stdp_pkg`:
  - state enum `stdp_state_t` (2 bits)
  - `TIMER_MAX` = 15
  - bin edges 3/7/11
  - delta constants 16/8/4/2
- Sub-module `stdp_delta_lut`: combinational 4-bit `time_diff` -> 8-bit delta.
- The FSM, timer, weight register and synaptic gate live in `stdp_controller`.

## Test plan

- Reset, then `pre_spike` while weight = 64 -> `syn_current` = 64 one cycle later; `weight` = 64, flag 0.
- pre at cycle 10, post at cycle 12 (timer 2) -> flag at cycle 13 with `ltp` = 1, `time_diff` = 2; `weight` = 80 at cycle 14.
- post at cycle 10, pre at cycle 19 -> `time_diff` = 9, `ltp` = 0; `weight` 64 -> 60.
- Saturation:
  - weight loaded to 250, pre/post at dt 1 -> 255.
  - weight loaded to 5, post/pre at dt 2 -> 0.
- Window and simultaneity:
  - pre with no post for 16 cycles -> back to IDLE; a later post only starts POST_SEEN and produces no update.
  - simultaneous pre+post from IDLE -> no flag.
- Overrides:
  - `learn_en` dropped in PRE_SEEN -> IDLE next cycle, no update.
  - `w_load` = 100 during UPDATE -> `weight` = 100 and the flag still pulses.
  - rst asserted during PRE_SEEN -> all outputs at reset values.
